// File: rtl/us_cmd_dispatch_pkg.sv
// Shared definitions for the upstream command FIFO: entry type codes, entry
// field positions and the dispatcher state encoding.
`timescale 1ns/1ps
package us_cmd_dispatch_pkg;

    typedef enum logic [1:0] {
        US_CMD_INVALID    = 2'd0,
        US_CMD_CPL_TYPE   = 2'd1,
        US_CMD_CPLD_TYPE  = 2'd2,
        US_CMD_WR32_TYPE  = 2'd3
    } us_cmd_type_e;

    localparam int ENTRY_TYPE_MSB = 63;
    localparam int ENTRY_TYPE_LSB = 62;
    localparam int ENTRY_LEN_MSB  = 61;
    localparam int ENTRY_LEN_LSB  = 57;
    localparam int ENTRY_ID_MSB   = 56;
    localparam int ENTRY_ID_LSB   = 55;
    localparam int ENTRY_DESC_MSB = 54;

    localparam int CPL_DESC_W = 55;
    localparam int REM_W      = 25;  // holds up to 2^24 bytes
    localparam int CHUNK_W    = 13;  // holds up to 4096 bytes

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CPL,
        ST_MWR_CALC,
        ST_MWR_REQ,
        ST_DONE
    } state_e;

    // Total transfer size: 2^len bytes, len clamped to [2, len_max].
    function automatic logic [REM_W-1:0] len_to_bytes(input logic [4:0] len, input int len_max);
        int e;
        e = int'(len);
        if (e > len_max) e = len_max;
        if (e < 2) e = 2;
        return REM_W'(1) << e;
    endfunction

endpackage

// File: rtl/us_mwr_chunker.sv
// Combinational MWr chunk sizer: the largest chunk that fits the remaining
// byte count, the max payload, and the space left before the next 4KB boundary.
`timescale 1ns/1ps
module us_mwr_chunker
    import us_cmd_dispatch_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = 128
) (
    input  logic [11:0]        addr_lo_i,
    input  logic [REM_W-1:0]   remaining_i,
    output logic [CHUNK_W-1:0] chunk_o
);

    logic [CHUNK_W-1:0] to_boundary;
    logic [CHUNK_W-1:0] cap;

    always_comb begin
        to_boundary = CHUNK_W'(4096) - {1'b0, addr_lo_i};
        cap         = (to_boundary < CHUNK_W'(MAX_PAYLOAD_BYTES)) ? to_boundary
                                                                   : CHUNK_W'(MAX_PAYLOAD_BYTES);
        chunk_o     = (remaining_i < REM_W'(cap)) ? remaining_i[CHUNK_W-1:0] : cap;
    end

endmodule

// File: rtl/us_cmd_dispatch.sv
// Upstream command FIFO consumer: turns CPL/CPLD entries into completion
// requests and WR32 entries into a sequence of 4KB-safe MWr requests.
`timescale 1ns/1ps
module us_cmd_dispatch
    import us_cmd_dispatch_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = 128,
    parameter int LEN_MAX           = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  us_cmd_fifo_empty_i,
    input  logic [127:0]          us_cmd_fifo_dout_i,
    output logic                  us_cmd_fifo_rd_en_o,
    output logic                  cpl_req_o,
    output logic                  cpl_with_data_o,
    output logic [CPL_DESC_W-1:0] cpl_desc_o,
    input  logic                  cpl_done_i,
    output logic                  mwr_req_o,
    output logic [31:0]           mwr_addr_o,
    output logic [9:0]            mwr_len_dw_o,
    input  logic                  mwr_done_i,
    output logic                  up_wr_cmd_compl_o,
    output logic [1:0]            cmd_id_o,
    output logic                  err_invalid_o,
    output logic                  busy_o
);

    state_e                state_q, state_d;
    logic                  cpl_req_q, cpl_req_d;
    logic                  with_data_q, with_data_d;
    logic [CPL_DESC_W-1:0] desc_q, desc_d;
    logic                  mwr_req_q, mwr_req_d;
    logic [31:0]           addr_q, addr_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [CHUNK_W-1:0]    chunk_q, chunk_d;
    logic [1:0]            id_q, id_d;
    logic                  compl_q, compl_d;
    logic                  err_q, err_d;
    logic                  busy_q;

    logic [CHUNK_W-1:0]    chunk_w;
    us_cmd_type_e          entry_type;
    logic                  unused_dout_hi;

    assign entry_type     = us_cmd_type_e'(us_cmd_fifo_dout_i[ENTRY_TYPE_MSB:ENTRY_TYPE_LSB]);
    assign unused_dout_hi = ^us_cmd_fifo_dout_i[127:64];

    us_mwr_chunker #(
        .MAX_PAYLOAD_BYTES (MAX_PAYLOAD_BYTES)
    ) u_chunker (
        .addr_lo_i   (addr_q[11:0]),
        .remaining_i (rem_q),
        .chunk_o     (chunk_w)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d             = state_q;
        cpl_req_d           = cpl_req_q;
        with_data_d         = with_data_q;
        desc_d              = desc_q;
        mwr_req_d           = mwr_req_q;
        addr_d              = addr_q;
        rem_d               = rem_q;
        chunk_d             = chunk_q;
        id_d                = id_q;
        compl_d             = 1'b0;
        err_d               = 1'b0;
        us_cmd_fifo_rd_en_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                us_cmd_fifo_rd_en_o = !us_cmd_fifo_empty_i;
                if (!us_cmd_fifo_empty_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                id_d = us_cmd_fifo_dout_i[ENTRY_ID_MSB:ENTRY_ID_LSB];
                case (entry_type)
                    US_CMD_CPL_TYPE, US_CMD_CPLD_TYPE: begin
                        cpl_req_d   = 1'b1;
                        with_data_d = (entry_type == US_CMD_CPLD_TYPE);
                        desc_d      = us_cmd_fifo_dout_i[ENTRY_DESC_MSB:0];
                        state_d     = ST_CPL;
                    end
                    US_CMD_WR32_TYPE: begin
                        addr_d  = {us_cmd_fifo_dout_i[31:2], 2'b00};
                        rem_d   = len_to_bytes(us_cmd_fifo_dout_i[ENTRY_LEN_MSB:ENTRY_LEN_LSB], LEN_MAX);
                        state_d = ST_MWR_CALC;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_CPL: begin
                if (cpl_done_i) begin
                    cpl_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_MWR_CALC: begin
                chunk_d   = chunk_w;
                mwr_req_d = 1'b1;
                state_d   = ST_MWR_REQ;
            end
            ST_MWR_REQ: begin
                if (mwr_done_i) begin
                    mwr_req_d = 1'b0;
                    addr_d    = addr_q + 32'(chunk_q);
                    rem_d     = rem_q - REM_W'(chunk_q);
                    if (rem_q == REM_W'(chunk_q)) begin
                        compl_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MWR_CALC;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cpl_req_q   <= 1'b0;
            with_data_q <= 1'b0;
            desc_q      <= '0;
            mwr_req_q   <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
            id_q        <= '0;
            compl_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpl_req_q   <= cpl_req_d;
            with_data_q <= with_data_d;
            desc_q      <= desc_d;
            mwr_req_q   <= mwr_req_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            chunk_q     <= chunk_d;
            id_q        <= id_d;
            compl_q     <= compl_d;
            err_q       <= err_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign cpl_req_o         = cpl_req_q;
    assign cpl_with_data_o   = with_data_q;
    assign cpl_desc_o        = desc_q;
    assign mwr_req_o         = mwr_req_q;
    assign mwr_addr_o        = addr_q;
    // A 4096-byte chunk (1024 DW) encodes as 0, as in the TLP length field.
    assign mwr_len_dw_o      = chunk_q[11:2];
    assign up_wr_cmd_compl_o = compl_q;
    assign cmd_id_o          = id_q;
    assign err_invalid_o     = err_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_us_cmd_dispatch.sv
// Directed bench for us_cmd_dispatch: FIFO model, delayed/tied-high TX done
// responder, negedge monitor logging requests, and hand-computed expectations.
`timescale 1ns/1ps
module tb_us_cmd_dispatch;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          empty;
    logic [127:0]  dout = '0;
    logic          rd_en;
    logic          cpl_req_o, cpl_with_data_o;
    logic [54:0]   cpl_desc_o;
    logic          cpl_done_i = 1'b0;
    logic          mwr_req_o;
    logic [31:0]   mwr_addr_o;
    logic [9:0]    mwr_len_dw_o;
    logic          mwr_done_i = 1'b0;
    logic          up_wr_cmd_compl_o;
    logic [1:0]    cmd_id_o;
    logic          err_invalid_o;
    logic          busy_o;

    always #5 clk = ~clk;

    us_cmd_dispatch #(.MAX_PAYLOAD_BYTES(128), .LEN_MAX(24)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .us_cmd_fifo_empty_i (empty),
        .us_cmd_fifo_dout_i  (dout),
        .us_cmd_fifo_rd_en_o (rd_en),
        .cpl_req_o           (cpl_req_o),
        .cpl_with_data_o     (cpl_with_data_o),
        .cpl_desc_o          (cpl_desc_o),
        .cpl_done_i          (cpl_done_i),
        .mwr_req_o           (mwr_req_o),
        .mwr_addr_o          (mwr_addr_o),
        .mwr_len_dw_o        (mwr_len_dw_o),
        .mwr_done_i          (mwr_done_i),
        .up_wr_cmd_compl_o   (up_wr_cmd_compl_o),
        .cmd_id_o            (cmd_id_o),
        .err_invalid_o       (err_invalid_o),
        .busy_o              (busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: data valid the cycle after the pop; holds entries across DUT reset.
    logic [127:0] fifo_mem [0:15];
    logic [3:0]   wr_ptr = '0;
    logic [3:0]   rd_ptr = '0;
    int           cyc = 0, last_pop_cyc = 0, pop_cnt = 0, busy_pop_cnt = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst_n && rd_en) begin
            dout   <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
            pop_cnt++;
            last_pop_cyc = cyc;
            if (busy_o) busy_pop_cnt++;
        end
    end

    // TX engine model: done after a programmable delay, or tied high.
    bit tie_done = 1'b0;
    int cpl_delay = 0, mwr_delay = 0, cpl_wait = 0, mwr_wait = 0;

    always @(negedge clk) begin
        if (tie_done) begin
            cpl_done_i = 1'b1;
            mwr_done_i = 1'b1;
        end else begin
            cpl_done_i = 1'b0;
            mwr_done_i = 1'b0;
            if (cpl_req_o) begin
                if (cpl_wait == cpl_delay) begin cpl_done_i = 1'b1; cpl_wait = 0; end
                else cpl_wait++;
            end else cpl_wait = 0;
            if (mwr_req_o) begin
                if (mwr_wait == mwr_delay) begin mwr_done_i = 1'b1; mwr_wait = 0; end
                else mwr_wait++;
            end else mwr_wait = 0;
        end
    end

    // Monitor: events 1=Cpl, 2=CplD, 3=MWr, logged on request rising edges.
    int          cpl_high = 0, req_high = 0, err_high = 0, compl_cnt = 0;
    logic        prev_cpl = 1'b0, prev_mwr = 1'b0;
    int          ev_log[$];
    int          lat_log[$];
    logic [54:0] desc_log[$];
    logic [31:0] addr_log[$];
    logic [9:0]  len_log[$];
    logic [1:0]  id_log[$];

    always @(negedge clk) begin
        cyc++;
        if (cpl_req_o) cpl_high++;
        if (cpl_req_o || mwr_req_o) req_high++;
        if (cpl_req_o && !prev_cpl) begin
            ev_log.push_back(cpl_with_data_o ? 2 : 1);
            desc_log.push_back(cpl_desc_o);
            lat_log.push_back(cyc - last_pop_cyc);
        end
        if (mwr_req_o && !prev_mwr) begin
            ev_log.push_back(3);
            addr_log.push_back(mwr_addr_o);
            len_log.push_back(mwr_len_dw_o);
        end
        if (up_wr_cmd_compl_o) begin
            compl_cnt++;
            id_log.push_back(cmd_id_o);
        end
        if (err_invalid_o) err_high++;
        prev_cpl = cpl_req_o;
        prev_mwr = mwr_req_o;
    end

    task automatic clear_logs();
        pop_cnt = 0; busy_pop_cnt = 0; cpl_high = 0; req_high = 0; err_high = 0; compl_cnt = 0;
        ev_log.delete(); lat_log.delete(); desc_log.delete();
        addr_log.delete(); len_log.delete(); id_log.delete();
    endtask

    function automatic logic [127:0] mk(input logic [1:0] typ, input logic [4:0] len,
                                         input logic [1:0] id, input logic [54:0] low);
        return {64'hA5A5_5A5A_F00D_CAFE, typ, len, id, low};
    endfunction

    task automatic push(input logic [127:0] e);
        @(negedge clk);
        fifo_mem[wr_ptr] = e;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (empty && !busy_o) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        check({tag, "_timeout"}, 64'(ok), 64'd1);
    endtask

    logic [54:0] desc1, desc2, desc3;
    logic [31:0] t3_addr [5] = '{32'h0FC0, 32'h1000, 32'h1080, 32'h1100, 32'h1180};
    int          t3_len  [5] = '{16, 32, 32, 32, 16};

    initial begin
        desc1 = {3'd2, 1'b0, 1'b0, 2'b01, 10'd1, 16'h0100, 8'h05, 8'h0F, 6'h04};
        desc2 = {3'd7, 1'b1, 1'b0, 2'b10, 10'd4, 16'hBEEF, 8'h3C, 8'hFF, 6'h00};
        desc3 = {3'd0, 1'b0, 1'b1, 2'b00, 10'd2, 16'h0001, 8'h99, 8'h01, 6'h3F};

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_flags", 64'({cpl_req_o, mwr_req_o, up_wr_cmd_compl_o, err_invalid_o, cpl_with_data_o}), 64'd0);
        check("rst_desc", 64'(cpl_desc_o), 64'd0);
        check("rst_mwr_id", 64'({mwr_addr_o, mwr_len_dw_o, cmd_id_o}), 64'd0);
        check("rst_rden_empty", 64'(rd_en), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("empty_no_pop", 64'(pop_cnt), 64'd0);

        // 1: CPL with a 5-cycle delayed done
        clear_logs(); cpl_delay = 5;
        push(mk(2'd1, 5'd0, 2'd0, desc1));
        wait_idle("t1", 50);
        check("t1_pops", 64'(pop_cnt), 64'd1);
        check("t1_ev", 64'(ev_log.size() == 1 && ev_log[0] == 1), 64'd1);
        check("t1_latency", 64'(lat_log[0]), 64'd2);
        check("t1_desc", 64'(desc_log[0]), 64'(desc1));
        check("t1_req_cycles", 64'(cpl_high), 64'd6);
        check("t1_no_compl", 64'(compl_cnt), 64'd0);
        cpl_delay = 0;

        // 2: WR32 64 bytes, single MWr
        clear_logs(); mwr_delay = 2;
        push(mk(2'd3, 5'd6, 2'd0, {23'd0, 32'h1000_0000}));
        wait_idle("t2", 50);
        check("t2_mwr_cnt", 64'(addr_log.size()), 64'd1);
        check("t2_addr", 64'(addr_log[0]), 64'h1000_0000);
        check("t2_len", 64'(len_log[0]), 64'd16);
        check("t2_compl", 64'(compl_cnt), 64'd1);
        check("t2_id", 64'(id_log[0]), 64'd0);

        // 3: WR32 512 bytes starting 64 bytes below a 4KB boundary
        clear_logs(); mwr_delay = 1;
        push(mk(2'd3, 5'd9, 2'd1, {23'd0, 32'h0000_0FC0}));
        wait_idle("t3", 200);
        check("t3_mwr_cnt", 64'(addr_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_addr%0d", i), 64'(addr_log[i]), 64'(t3_addr[i]));
            check($sformatf("t3_len%0d", i), 64'(len_log[i]), 64'(t3_len[i]));
        end
        check("t3_compl", 64'(compl_cnt), 64'd1);
        check("t3_id", 64'(id_log[0]), 64'd1);

        // 4: back-to-back CPLD, WR32 (unaligned host addr), CPL with done tied high
        clear_logs(); tie_done = 1'b1;
        push(mk(2'd2, 5'd0, 2'd0, desc2));
        push(mk(2'd3, 5'd2, 2'd2, {23'd0, 32'h2000_0006}));
        push(mk(2'd1, 5'd0, 2'd0, desc3));
        wait_idle("t4", 100);
        tie_done = 1'b0;
        check("t4_ev_cnt", 64'(ev_log.size()), 64'd3);
        check("t4_order", 64'(ev_log[0] == 2 && ev_log[1] == 3 && ev_log[2] == 1), 64'd1);
        check("t4_cpld_desc", 64'(desc_log[0]), 64'(desc2));
        check("t4_cpl_desc", 64'(desc_log[1]), 64'(desc3));
        check("t4_addr", 64'(addr_log[0]), 64'h2000_0004);
        check("t4_len", 64'(len_log[0]), 64'd1);
        check("t4_id", 64'(id_log[0]), 64'd2);
        check("t4_pop_busy", 64'(busy_pop_cnt), 64'd0);
        check("t4_pops", 64'(pop_cnt), 64'd3);

        // 5: INVALID entry
        clear_logs();
        push(mk(2'd0, 5'd3, 2'd1, 55'h123));
        wait_idle("t5", 50);
        check("t5_pops", 64'(pop_cnt), 64'd1);
        check("t5_err_pulse", 64'(err_high), 64'd1);
        check("t5_no_req", 64'(req_high), 64'd0);
        check("t5_no_compl", 64'(compl_cnt), 64'd0);

        // 7: len below the 4-byte floor, last DW before the top of the address space
        clear_logs(); mwr_delay = 0;
        push(mk(2'd3, 5'd0, 2'd3, {23'd0, 32'hFFFF_FFFC}));
        wait_idle("t7", 50);
        check("t7_mwr", 64'({addr_log.size() == 1, addr_log[0], len_log[0]}), 64'({1'b1, 32'hFFFF_FFFC, 10'd1}));
        check("t7_id", 64'(id_log[0]), 64'd3);

        // 6: reset during the second chunk of a WR32; the queued CPL still runs
        clear_logs(); mwr_delay = 3;
        push(mk(2'd3, 5'd9, 2'd1, {23'd0, 32'h0000_0FC0}));
        push(mk(2'd1, 5'd0, 2'd0, desc1));
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (addr_log.size() == 2) begin seen = 1'b1; break; end
            end
            check("t6_reach_chunk2", 64'(seen), 64'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_flags", 64'({busy_o, cpl_req_o, mwr_req_o, up_wr_cmd_compl_o, err_invalid_o, cpl_with_data_o}), 64'd0);
        check("t6_rst_vals", 64'({mwr_addr_o, mwr_len_dw_o, cmd_id_o}), 64'd0);
        @(negedge clk);
        #1;
        clear_logs();
        rst_n = 1'b1;
        wait_idle("t6", 50);
        check("t6_ev", 64'(ev_log.size() == 1 && ev_log[0] == 1), 64'd1);
        check("t6_desc", 64'(desc_log[0]), 64'(desc1));
        check("t6_no_compl", 64'(compl_cnt), 64'd0);
        check("t6_no_mwr", 64'(addr_log.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
